// File: rtl/ksa_pkg.sv
// Shared constants and state type for the multi-word Kogge-Stone adder front-end.
package ksa_pkg;

   localparam int KSA_WIDTH     = 32;
   localparam int KSA_WORDS_MAX = 8;

   // IDLE: the next accepted word opens an operation; CHAIN: carry is chained from carry_q.
   typedef enum logic {
      IDLE  = 1'b0,
      CHAIN = 1'b1
   } ksa_mw_state_t;

endpackage

// File: rtl/kogge_stone_adder.sv
// Parallel-prefix (Kogge-Stone) adder with carry-in; purely combinational.
module kogge_stone_adder
   import ksa_pkg::*;
#(
   parameter int WIDTH = KSA_WIDTH
) (
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             cin,
   output logic [WIDTH-1:0] sum,
   output logic             cout
);

   localparam int LEVELS = $clog2(WIDTH);

   // Level 0 holds bitwise generate/propagate; level k spans 2^k bits.
   logic [LEVELS:0][WIDTH-1:0] gl;
   logic [LEVELS:0][WIDTH-1:0] pl;

   // Prefix tree: cin is folded into bit 0 so gl[LEVELS][i] is the carry out of bit i.
   always_comb begin
      gl = '0;
      pl = '0;
      gl[0]    = A & B;
      pl[0]    = A ^ B;
      gl[0][0] = (A[0] & B[0]) | ((A[0] ^ B[0]) & cin);
      for (int lvl = 1; lvl <= LEVELS; lvl++) begin
         gl[lvl] = gl[lvl-1];
         pl[lvl] = pl[lvl-1];
         for (int i = (1 << (lvl - 1)); i < WIDTH; i++) begin
            gl[lvl][i] = gl[lvl-1][i] | (pl[lvl-1][i] & gl[lvl-1][i-(1 << (lvl - 1))]);
            pl[lvl][i] = pl[lvl-1][i] & pl[lvl-1][i-(1 << (lvl - 1))];
         end
      end
   end

   // Sum bits: propagate XOR incoming carry; bit 0 sees cin directly.
   always_comb begin
      sum    = '0;
      sum[0] = pl[0][0] ^ cin;
      for (int i = 1; i < WIDTH; i++) begin
         sum[i] = pl[0][i] ^ gl[LEVELS][i-1];
      end
      cout = gl[LEVELS][WIDTH-1];
   end

endmodule

// File: rtl/ksa_multiword_adder.sv
// Streaming multi-word adder: one word per cycle, LS word first, carry chained
// through carry_q. One output register stage; in_ready = !out_valid || out_ready.
// Handshake: a transfer happens on a rising edge where valid && ready; a pending
// output word holds all its fields until it is taken.
module ksa_multiword_adder
   import ksa_pkg::*;
#(
   parameter int WIDTH     = KSA_WIDTH,
   parameter int WORDS_MAX = KSA_WORDS_MAX
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_cin,
   input  logic             in_last,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_last,
   output logic             out_cout,
   output logic             out_err,
   output logic             busy
);

   localparam int CNT_W = $clog2(WORDS_MAX);

   ksa_mw_state_t    state_q, state_d;
   logic [CNT_W-1:0] idx_q, idx_d;
   logic             carry_q, carry_d;
   logic             valid_q, valid_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             last_q, last_d;
   logic             cout_q, cout_d;
   logic             err_q, err_d;

   logic             accept;
   logic             at_max;
   logic             add_cin;
   logic [WIDTH-1:0] add_sum;
   logic             add_cout;

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready;
   assign at_max   = (idx_q == CNT_W'(WORDS_MAX - 1));
   assign add_cin  = (state_q == IDLE) ? in_cin : carry_q;

   kogge_stone_adder #(.WIDTH(WIDTH)) u_adder (
      .A    (in_a),
      .B    (in_b),
      .cin  (add_cin),
      .sum  (add_sum),
      .cout (add_cout)
   );

   // Next-state, counter and output-register update on accept or drain.
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      carry_d = carry_q;
      valid_d = valid_q;
      sum_d   = sum_q;
      last_d  = last_q;
      cout_d  = cout_q;
      err_d   = err_q;
      if (accept) begin
         valid_d = 1'b1;
         sum_d   = add_sum;
         carry_d = add_cout;
         last_d  = in_last || at_max;
         cout_d  = (in_last || at_max) ? add_cout : 1'b0;
         err_d   = at_max && !in_last;
         if (in_last || at_max) begin
            state_d = IDLE;
            idx_d   = '0;
         end else begin
            state_d = CHAIN;
            idx_d   = idx_q + CNT_W'(1);
         end
      end else if (out_ready) begin
         valid_d = 1'b0;
      end
   end

   // State and output registers; reset discards any partial operation.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         idx_q   <= '0;
         carry_q <= 1'b0;
         valid_q <= 1'b0;
         sum_q   <= '0;
         last_q  <= 1'b0;
         cout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         carry_q <= carry_d;
         valid_q <= valid_d;
         sum_q   <= sum_d;
         last_q  <= last_d;
         cout_q  <= cout_d;
         err_q   <= err_d;
      end
   end

   assign out_valid = valid_q;
   assign out_sum   = sum_q;
   assign out_last  = last_q;
   assign out_cout  = cout_q;
   assign out_err   = err_q;
   assign busy      = (state_q == CHAIN);

endmodule

// File: tb/tb_ksa_multiword_adder.sv
// Bench for ksa_multiword_adder: directed cases with literal expectations, then a
// randomized stream scored against a full-width arithmetic reference.
module tb_ksa_multiword_adder;

   localparam int W    = 32;
   localparam int WMAX = 4;
   localparam int FW   = WMAX * W + 1;

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  in_a;
   logic [W-1:0]  in_b;
   logic          in_cin;
   logic          in_last;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  out_sum;
   logic          out_last;
   logic          out_cout;
   logic          out_err;
   logic          busy;

   int n_checks = 0;
   int n_fail   = 0;

   logic [W+2:0] exp_q[$];
   logic [W-1:0] st_a[$];
   logic [W-1:0] st_b[$];
   logic         st_cin[$];
   logic         st_last[$];

   logic         chk_en = 1'b0;
   logic         drv_done;
   logic         hold_prev = 1'b0;
   logic [W-1:0] prev_sum;
   logic [W+2:0] e;

   ksa_multiword_adder #(.WIDTH(W), .WORDS_MAX(WMAX)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_a      (in_a),
      .in_b      (in_b),
      .in_cin    (in_cin),
      .in_last   (in_last),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_last  (out_last),
      .out_cout  (out_cout),
      .out_err   (out_err),
      .busy      (busy)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Present one word and hold it until it is taken (bounded).
   task automatic send_word(input logic [W-1:0] a, input logic [W-1:0] b,
                            input logic cin, input logic last);
      int   waited;
      logic got;
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      in_cin   = cin;
      in_last  = last;
      waited   = 0;
      got      = 1'b0;
      while (!got && waited < 200) begin
         @(negedge clk);
         got = in_ready;
         @(posedge clk);
         #1;
         waited++;
      end
      if (!got) begin
         n_checks++;
         n_fail++;
         $display("FAIL send_timeout: in_ready stayed 0 for %0d cycles", waited);
      end
      in_valid = 1'b0;
   endtask

   task automatic idle_cycle();
      in_valid = 1'b0;
      in_a     = $urandom;
      in_b     = $urandom;
      in_cin   = 1'($urandom_range(0, 1));
      in_last  = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
   endtask

   function automatic logic [W-1:0] rand_word();
      case ($urandom_range(0, 3))
         0:       return '1;
         1:       return '0;
         default: return $urandom;
      endcase
   endfunction

   // Reference: split the word stream into operations (in_last or WMAX words),
   // add each operation as one wide integer, and slice it back into words.
   task automatic build_expected();
      int           pos;
      logic         seg_cin;
      logic [W-1:0] sa[$];
      logic [W-1:0] sb[$];
      logic [FW-1:0] fa, fb, full;
      logic         fin, trunc;
      pos     = 0;
      seg_cin = 1'b0;
      for (int k = 0; k < st_a.size(); k++) begin
         if (pos == 0) seg_cin = st_cin[k];
         sa.push_back(st_a[k]);
         sb.push_back(st_b[k]);
         pos++;
         if (st_last[k] || pos == WMAX) begin
            fa = '0;
            fb = '0;
            for (int j = 0; j < pos; j++) begin
               fa[j*W +: W] = sa[j];
               fb[j*W +: W] = sb[j];
            end
            full  = fa + fb + {{(FW-1){1'b0}}, seg_cin};
            trunc = (pos == WMAX) && !st_last[k];
            for (int j = 0; j < pos; j++) begin
               fin = (j == pos - 1);
               exp_q.push_back({fin && trunc, fin ? full[pos*W] : 1'b0, fin, full[j*W +: W]});
            end
            pos = 0;
            sa.delete();
            sb.delete();
         end
      end
   endtask

   // Scoreboard compare: every transferred output word against the reference,
   // and frozen outputs while a word is stalled.
   always @(negedge clk) begin
      if (chk_en && !rst) begin
         if (hold_prev) begin
            chk("hold_valid", 64'(out_valid), 64'd1);
            chk("hold_sum", 64'(out_sum), 64'(prev_sum));
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               n_checks++;
               n_fail++;
               $display("FAIL unexpected_word: got sum 0x%0h expected no word", out_sum);
            end else begin
               e = exp_q.pop_front();
               chk("stream_sum", 64'(out_sum), 64'(e[W-1:0]));
               chk("stream_last", 64'(out_last), 64'(e[W]));
               chk("stream_cout", 64'(out_cout), 64'(e[W+1]));
               chk("stream_err", 64'(out_err), 64'(e[W+2]));
            end
         end
         hold_prev = out_valid && !out_ready;
         prev_sum  = out_sum;
      end else begin
         hold_prev = 1'b0;
      end
   end

   initial begin
      int n_ops, len, waited;
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_a      = '0;
      in_b      = '0;
      in_cin    = 1'b0;
      in_last   = 1'b0;
      out_ready = 1'b1;
      drv_done  = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // reset state
      @(negedge clk);
      chk("rst_out_valid", 64'(out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_in_ready", 64'(in_ready), 64'd1);
      chk("rst_out_sum", 64'(out_sum), 64'd0);
      chk("rst_out_last", 64'(out_last), 64'd0);
      chk("rst_out_cout", 64'(out_cout), 64'd0);
      chk("rst_out_err", 64'(out_err), 64'd0);
      @(posedge clk);
      #1;

      // single-word operation
      send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b1);
      chk("single_valid", 64'(out_valid), 64'd1);
      chk("single_sum", 64'(out_sum), 64'h0);
      chk("single_cout", 64'(out_cout), 64'd1);
      chk("single_last", 64'(out_last), 64'd1);
      chk("single_err", 64'(out_err), 64'd0);
      idle_cycle();
      chk("single_drain", 64'(out_valid), 64'd0);

      // two-word carry chain
      send_word(32'hFFFF_FFFF, 32'h1, 1'b1, 1'b0);
      chk("chain0_sum", 64'(out_sum), 64'h1);
      chk("chain0_last", 64'(out_last), 64'd0);
      chk("chain0_cout", 64'(out_cout), 64'd0);
      chk("chain0_busy", 64'(busy), 64'd1);
      send_word(32'h7, 32'h8, 1'b0, 1'b1);
      chk("chain1_sum", 64'(out_sum), 64'h10);
      chk("chain1_cout", 64'(out_cout), 64'd0);
      chk("chain1_last", 64'(out_last), 64'd1);
      chk("chain1_busy", 64'(busy), 64'd0);
      idle_cycle();

      // truncation at WMAX words
      send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      chk("trunc0_sum", 64'(out_sum), 64'h0);
      for (int i = 1; i < WMAX; i++) begin
         send_word(32'hFFFF_FFFF, 32'h0, 1'b0, 1'b0);
         chk("truncn_sum", 64'(out_sum), 64'h0);
         chk("truncn_last", 64'(out_last), 64'(i == WMAX - 1));
      end
      chk("trunc_err", 64'(out_err), 64'd1);
      chk("trunc_cout", 64'(out_cout), 64'd1);
      chk("trunc_busy", 64'(busy), 64'd0);
      send_word(32'h0, 32'h0, 1'b0, 1'b1);
      chk("after_trunc_sum", 64'(out_sum), 64'h0);
      chk("after_trunc_err", 64'(out_err), 64'd0);
      chk("after_trunc_last", 64'(out_last), 64'd1);
      idle_cycle();

      // back-pressure
      out_ready = 1'b0;
      send_word(32'h10, 32'h20, 1'b0, 1'b0);
      in_valid = 1'b1;
      in_a     = 32'h1;
      in_b     = 32'h2;
      in_cin   = 1'b0;
      in_last  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_in_ready", 64'(in_ready), 64'd0);
         chk("bp_out_valid", 64'(out_valid), 64'd1);
         chk("bp_out_sum", 64'(out_sum), 64'h30);
         chk("bp_out_last", 64'(out_last), 64'd0);
      end
      @(posedge clk);
      #1 out_ready = 1'b1;
      send_word(32'h1, 32'h2, 1'b0, 1'b1);
      chk("bp_next_valid", 64'(out_valid), 64'd1);
      chk("bp_next_sum", 64'(out_sum), 64'h3);
      chk("bp_next_last", 64'(out_last), 64'd1);
      idle_cycle();
      chk("bp_drain", 64'(out_valid), 64'd0);

      // reset mid-operation
      send_word(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      chk("midrst_valid", 64'(out_valid), 64'd0);
      chk("midrst_busy", 64'(busy), 64'd0);
      send_word(32'h0, 32'h0, 1'b0, 1'b1);
      chk("midrst_sum", 64'(out_sum), 64'h0);
      chk("midrst_last", 64'(out_last), 64'd1);
      idle_cycle();

      // randomized stream of 1..8-word operations
      n_ops = 100;
      for (int op = 0; op < n_ops; op++) begin
         len = $urandom_range(1, 8);
         for (int j = 0; j < len; j++) begin
            st_a.push_back(rand_word());
            st_b.push_back(rand_word());
            st_cin.push_back(1'($urandom_range(0, 1)));
            st_last.push_back(j == len - 1);
         end
      end
      build_expected();
      chk_en = 1'b1;
      fork
         begin
            for (int k = 0; k < st_a.size(); k++) begin
               if ($urandom_range(0, 3) == 0) idle_cycle();
               send_word(st_a[k], st_b[k], st_cin[k], st_last[k]);
            end
            drv_done = 1'b1;
         end
         begin
            while (!drv_done) begin
               out_ready = ($urandom_range(0, 3) != 0);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      waited = 0;
      while (exp_q.size() != 0 && waited < 500) begin
         @(posedge clk);
         #1;
         waited++;
      end
      @(negedge clk);
      chk("stream_drained", 64'(exp_q.size()), 64'd0);
      chk_en = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/ksa_multiword_adder.md
# ksa_multiword_adder

Streaming front-end that adds two multi-word operands least-significant word first, one word per cycle, through a single `kogge_stone_adder` instance. The carry out of each word is chained into the carry in of the next. Operand words arrive on a valid/ready input stream from the operand source. Registered sum words leave on a valid/ready output stream toward the result consumer.

## Interface
- `WIDTH`, 32: word width; equals the operand width of the instantiated `kogge_stone_adder`.
- `WORDS_MAX`, 8: maximum words per operation, ≥ 2.
- `CNT_W`, `$clog2(WORDS_MAX)`: word-index counter width (localparam).

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `in_valid`  in  1  input word present.
- `in_ready`  out  1  block accepts the input word this cycle.
- `in_a`  in  WIDTH  operand A word.
- `in_b`  in  WIDTH  operand B word.
- `in_cin`  in  1  operation carry-in; sampled only on the first word of an operation.
- `in_last`  in  1  marks the most-significant word.
- `out_valid`  out  1  result word present.
- `out_ready`  in  1  consumer accepts the result word.
- `out_sum`  out  WIDTH  sum word.
- `out_last`  out  1  final word of the operation.
- `out_cout`  out  1  final carry-out; meaningful only when `out_last`=1, otherwise 0.
- `out_err`  out  1  operation was truncated at `WORDS_MAX`; qualified by `out_last`.
- `busy`  out  1  an operation is in progress (state CHAIN).

## Operation
- **Accept rule:** a word is accepted when `in_valid && in_ready`.
- **Ready rule:** `in_ready = !out_valid || out_ready`. This gives one register stage with full throughput and no skid buffer.
- **FSM states:**
  - IDLE: next accepted word is the first word of an operation.
  - CHAIN: operation in progress.
- **Adder carry-in:** `in_cin` in IDLE, `carry_q` in CHAIN.
- **On accept:**
  - `out_sum` ← adder `sum`; `carry_q` ← adder `cout`.
  - `out_last` ← `in_last || (idx == WORDS_MAX-1)`.
  - `out_cout` ← `cout` if `out_last`, else 0.
  - `out_err` ← `(idx == WORDS_MAX-1) && !in_last`.
  - `out_valid` ← 1.
- **Transitions and counter:**
  - If the new `out_last`=1: state → IDLE, `idx` → 0.
  - Otherwise: state → CHAIN, `idx` → `idx+1`.
- **No accept, `out_ready`=1:** `out_valid` ← 0. All other output registers hold.
- **Output hold:** while `out_valid && !out_ready`, outputs are frozen. Accept is impossible in this condition.
- **Carry width:** sum is WIDTH bits modulo 2^WIDTH. Carry propagates only through `carry_q`; there is no wider arithmetic.
- **Truncation:** a word arriving after a truncated last word starts a new operation and uses `in_cin`.
- **Reset values:**
  - `out_valid` = 0, `out_sum` = 0, `out_last` = 0, `out_cout` = 0, `out_err` = 0.
  - `busy` = 0, state = IDLE, `idx` = 0, `carry_q` = 0.
  - `in_ready` = 1 from the first cycle after reset.
- **Reset mid-operation:** the partial operation is discarded, including any pending output word. The next word after reset is treated as a first word.
- **Idle input:** `in_a`, `in_b`, `in_cin` and `in_last` are ignored when `in_valid`=0.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible at outputs after edge N, i.e. `out_valid`=1 in cycle N+1.
- Throughput is 1 word/cycle when `out_ready` is held 1.
- Simultaneous output drain and new accept in the same cycle is legal: `out_valid` stays 1 with the new word.
- The adder path (operands → `sum`/`cout` → registers) is the single combinational path; there is no other logic in series beyond the cin mux.
- `busy` is registered and rises the cycle after the first non-last word is accepted.

## Structure
- **Package `ksa_pkg`:**
  - state enum `ksa_mw_state_t` {IDLE, CHAIN};
  - default `WIDTH` and `WORDS_MAX` constants.
- **Sub-module:** one `kogge_stone_adder` instance, ports `A`, `B`, `cin`, `sum`, `cout`. No other sub-modules.
- **Interface:** the existing adder interface is extended with `clk`, `rst` and the handshake signals for this block's bench.

## Test plan
- **Single-word operation:** WIDTH=32; `in_a`=0xFFFFFFFF, `in_b`=0x1, `in_cin`=0, `in_last`=1 → next cycle `out_sum`=0x0, `out_cout`=1, `out_last`=1, `out_err`=0.
- **Two-word carry chain:**
  - word0: 0xFFFFFFFF + 0x00000001, `in_cin`=1 → `out_sum`=0x00000001, `out_last`=0.
  - word1: 0x7 + 0x8, `in_last`=1 → `out_sum`=0x10, `out_cout`=0.
- **Back-pressure:** hold `out_ready`=0 for 3 cycles with a result pending → `in_ready`=0, outputs unchanged. Release → each word is delivered exactly once, in order, with no gap when `in_valid` is held.
- **Truncation:** `WORDS_MAX`=4; send 4 words with `in_last`=0 → 4th output has `out_last`=1, `out_err`=1. A 5th word with `in_cin`=0 uses cin=0 regardless of the previous carry.
- **Reset mid-operation:**
  - word0: 0xFFFFFFFF + 0x1 (carry 1 stored), then assert `rst` one cycle → `out_valid`=0, `busy`=0.
  - next word 0x0 + 0x0, `in_cin`=0, `in_last`=1 → `out_sum`=0x0 (stored carry is not applied).
- **Streaming:** 100 random 1..8-word operations with random `out_ready` → bench scoreboard reconstructs full-width sums and matches a reference model exactly.
